lsu_ctrl: RTL and testbench

- Initiator side of the data-memory interface: the CPU load/store unit that drives a word-aligned, byte-enabled, synchronous-read data RAM.
- Accepts one load/store request at a time from the pipeline.
- Aligned accesses issue one memory access. Misaligned accesses that straddle a word boundary are split into two accesses.
- Merges read data, sign/zero-extends it, and returns a registered response; the pipeline stalls on `req_ready_o`.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_ctrl.sv | 143 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned BYTES = 4;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [1:0] {
        MT_BYTE = 2'b00,
        MT_HALF = 2'b01,
        MT_WORD = 2'b10,
        MT_RSVD = 2'b11
    } memtype_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        FIN
    } lsu_state_t;

    // Request captured at acceptance.
    typedef struct packed {
        logic            we;
        memtype_t        mt;
        logic            sign;
        logic [1:0]      off;
        logic [XLEN-1:0] wa;
        logic [XLEN-1:0] wd;
    } lsu_req_t;

    // Access size in bytes; the reserved type reports 0.
    function automatic logic [2:0] mt_bytes(input memtype_t mt);
        case (mt)
            MT_BYTE: return 3'd1;
            MT_HALF: return 3'd2;
            MT_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // True when the access crosses into the next word.
    function automatic logic is_split(input memtype_t mt, input logic [1:0] off);
        return ({1'b0, off} + mt_bytes(mt)) > 3'(BYTES);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: enables, write shifting and read merge/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  memtype_t    mt,
    input  logic [1:0]  off,
    input  logic        sign,
    input  logic [31:0] wd,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] rd
);

    logic [7:0]  be8;
    logic [63:0] wd64;
    logic [31:0] rsh;

    // Lane enables and write data for the two word-sized halves of a 64-bit window.
    always_comb begin
        be8   = 8'(8'((16'd1 << mt_bytes(mt)) - 16'd1) << off);
        be0   = be8[3:0];
        be1   = be8[7:4];
        split = is_split(mt, off);
        wd64  = {32'h0, wd} << {off, 3'b000};
        wd0   = wd64[31:0];
        wd1   = wd64[63:32];
    end

    // Shift the read window down to the addressed byte, then size and extend.
    always_comb begin
        rsh = 32'({(split ? hi : 32'h0), lo} >> {off, 3'b000});
        case (mt)
            MT_BYTE: rd = {{24{sign & rsh[7]}}, rsh[7:0]};
            MT_HALF: rd = {{16{sign & rsh[15]}}, rsh[15:0]};
            MT_WORD: rd = rsh;
            default: rd = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit initiator: one request at a time, splits word-crossing accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             write_en_i,
    input  logic [1:0]       memtype_i,
    input  logic             memsign_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             resp_valid_o,
    output logic [WIDTH-1:0] rd_o,
    output logic             err_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [WIDTH-1:0] mem_a_o,
    output logic [WIDTH-1:0] mem_wd_o,
    input  logic [WIDTH-1:0] mem_rd_i
);

    lsu_state_t       state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             resp_q, resp_d;
    logic             err_q, err_d;

    memtype_t         mt_in;
    logic             in_err;
    logic [3:0]       be0, be1;
    logic             split;
    logic [WIDTH-1:0] wd0, wd1, rd_merged, lo_sel;

    assign mt_in  = memtype_t'(memtype_i);
    assign in_err = (mt_in == MT_RSVD) || (is_split(mt_in, a_i[1:0]) && !MISALIGN_EN);
    // In FIN the live read word is the low word unless the access was split.
    assign lo_sel = split ? lo_q : mem_rd_i;

    lsu_align u_align (
        .mt    (req_q.mt),
        .off   (req_q.off),
        .sign  (req_q.sign),
        .wd    (req_q.wd),
        .lo    (lo_sel),
        .hi    (mem_rd_i),
        .be0   (be0),
        .be1   (be1),
        .split (split),
        .wd0   (wd0),
        .wd1   (wd1),
        .rd    (rd_merged)
    );

    // Next-state, register updates and memory strobes from registered state.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        resp_d   = 1'b0;
        err_d    = 1'b0;
        mem_en_o = 1'b0;
        mem_we_o = 1'b0;
        mem_be_o = 4'h0;
        mem_a_o  = '0;
        mem_wd_o = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (in_err) begin
                        resp_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        req_d.we   = write_en_i;
                        req_d.mt   = mt_in;
                        req_d.sign = memsign_i;
                        req_d.off  = a_i[1:0];
                        req_d.wa   = {a_i[WIDTH-1:2], 2'b00};
                        req_d.wd   = wd_i;
                        state_d    = ACC0;
                    end
                end
            end
            ACC0: begin
                mem_en_o = 1'b1;
                mem_we_o = req_q.we;
                mem_be_o = be0;
                mem_a_o  = req_q.wa;
                mem_wd_o = wd0;
                state_d  = split ? ACC1 : FIN;
            end
            ACC1: begin
                mem_en_o = 1'b1;
                mem_we_o = req_q.we;
                mem_be_o = be1;
                mem_a_o  = req_q.wa + WIDTH'(4);
                mem_wd_o = wd1;
                lo_d     = mem_rd_i;
                state_d  = FIN;
            end
            FIN: begin
                resp_d = 1'b1;
                if (!req_q.we) begin
                    rd_d = rd_merged;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            lo_q    <= '0;
            rd_q    <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_q;
    assign err_o        = err_q;
    assign rd_o         = rd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-enabled synchronous RAM model.
module tb_lsu_ctrl;

    logic        clk, rst_n;
    logic        req_valid, write_en, memsign;
    logic [1:0]  memtype;
    logic [31:0] a, wd;

    logic        req_ready, resp_valid, err, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] rd, mem_a, mem_wd;
    logic [31:0] mem_rd;

    logic        nm_ready, nm_resp_valid, nm_err, nm_mem_en, nm_mem_we;
    logic [3:0]  nm_mem_be;
    logic [31:0] nm_rd, nm_mem_a, nm_mem_wd;

    logic [31:0] mem [logic [31:0]];
    logic        pl_en;
    logic [31:0] pl_a, pl_d, mem_w;

    int n_chk = 0;
    int n_pass = 0;

    int          n_str, r_off, nm_off;
    int          s_off [4];
    logic [31:0] s_a [4];
    logic [31:0] s_wd [4];
    logic [3:0]  s_be [4];
    logic        s_we [4];
    logic        r_err, nm_err_s, nm_en_seen;
    logic [31:0] r_rd, nm_rd_s;

    lsu_ctrl #(.WIDTH(32), .MISALIGN_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .write_en_i(write_en), .memtype_i(memtype), .memsign_i(memsign), .a_i(a), .wd_i(wd),
        .resp_valid_o(resp_valid), .rd_o(rd), .err_o(err), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    lsu_ctrl #(.WIDTH(32), .MISALIGN_EN(1'b0)) u_dut_nm (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(nm_ready),
        .write_en_i(write_en), .memtype_i(memtype), .memsign_i(memsign), .a_i(a), .wd_i(wd),
        .resp_valid_o(nm_resp_valid), .rd_o(nm_rd), .err_o(nm_err), .mem_en_o(nm_mem_en),
        .mem_we_o(nm_mem_we), .mem_be_o(nm_mem_be), .mem_a_o(nm_mem_a), .mem_wd_o(nm_mem_wd),
        .mem_rd_i(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdw(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 32'h0;
    endfunction

    // RAM model: backdoor preload, byte-enabled writes, one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] = pl_d;
        if (mem_en) begin
            if (mem_we) begin
                mem_w = rdw(mem_a);
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem_w[8*i +: 8] = mem_wd[8*i +: 8];
                mem[mem_a] = mem_w;
            end else begin
                mem_rd <= rdw(mem_a);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = addr; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request and record strobes and response timing relative to acceptance.
    task automatic run_req(input logic we, input logic [1:0] mt, input logic sg,
                           input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        chk("ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; write_en = we; memtype = mt; memsign = sg; a = addr; wd = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_str = 0; r_off = 0; nm_off = 0; nm_en_seen = 1'b0;
        r_err = 1'b0; r_rd = 32'h0; nm_err_s = 1'b0; nm_rd_s = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (nm_mem_en) nm_en_seen = 1'b1;
            if (nm_resp_valid && nm_off == 0) begin
                nm_off = k; nm_err_s = nm_err; nm_rd_s = nm_rd;
            end
            if (mem_en && n_str < 4) begin
                s_off[n_str] = k; s_a[n_str] = mem_a; s_be[n_str] = mem_be;
                s_wd[n_str] = mem_wd; s_we[n_str] = mem_we;
                n_str++;
            end
            if (resp_valid) begin
                r_off = k; r_err = err; r_rd = rd;
                break;
            end
        end
        if (r_off != 0) begin
            @(negedge clk);
            chk("resp_pulse", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; write_en = 1'b0; memtype = 2'b00;
        memsign = 1'b0; a = 32'h0; wd = 32'h0; pl_en = 1'b0; pl_a = 32'h0; pl_d = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_rd", rd, 32'h0);
        rst_n = 1'b1;

        // word store
        run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        chk("sw_nstr", 32'(n_str), 32'd1);
        chk("sw_off", 32'(s_off[0]), 32'd1);
        chk("sw_a", s_a[0], 32'h100);
        chk("sw_be", 32'(s_be[0]), 32'hF);
        chk("sw_wd", s_wd[0], 32'hDEADBEEF);
        chk("sw_we", 32'(s_we[0]), 32'd1);
        chk("sw_resp", 32'(r_off), 32'd3);
        chk("sw_err", 32'(r_err), 32'd0);
        chk("sw_mem", rdw(32'h100), 32'hDEADBEEF);

        // byte load, signed and unsigned
        preload(32'h100, 32'h80123456);
        run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        chk("lb_nstr", 32'(n_str), 32'd1);
        chk("lb_be", 32'(s_be[0]), 32'h8);
        chk("lb_we", 32'(s_we[0]), 32'd0);
        chk("lb_resp", 32'(r_off), 32'd3);
        chk("lb_rd", r_rd, 32'hFFFFFF80);
        run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        chk("lbu_rd", r_rd, 32'h00000080);

        // split word load
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        run_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        chk("lws_nstr", 32'(n_str), 32'd2);
        chk("lws_a0", s_a[0], 32'h100);
        chk("lws_be0", 32'(s_be[0]), 32'hC);
        chk("lws_a1", s_a[1], 32'h104);
        chk("lws_be1", 32'(s_be[1]), 32'h3);
        chk("lws_off1", 32'(s_off[1]), 32'd2);
        chk("lws_resp", 32'(r_off), 32'd4);
        chk("lws_rd", r_rd, 32'h66554433);

        // split half store; rd_o must hold
        run_req(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000ABCD);
        chk("shs_nstr", 32'(n_str), 32'd2);
        chk("shs_a0", s_a[0], 32'h100);
        chk("shs_be0", 32'(s_be[0]), 32'h8);
        chk("shs_wd0", s_wd[0], 32'hCD000000);
        chk("shs_a1", s_a[1], 32'h104);
        chk("shs_be1", 32'(s_be[1]), 32'h1);
        chk("shs_wd1", s_wd[1], 32'h000000AB);
        chk("shs_resp", 32'(r_off), 32'd4);
        chk("shs_rdhold", r_rd, 32'h66554433);
        chk("shs_mem0", rdw(32'h100), 32'hCD332211);
        chk("shs_mem1", rdw(32'h104), 32'h887766AB);

        // split half load: merged on the main DUT, rejected with misalignment off
        run_req(1'b0, 2'b01, 1'b1, 32'h103, 32'h0);
        chk("lhs_rd", r_rd, 32'hFFFFABCD);
        chk("nm_off", 32'(nm_off), 32'd1);
        chk("nm_err", 32'(nm_err_s), 32'd1);
        chk("nm_noen", 32'(nm_en_seen), 32'd0);
        chk("nm_rd", nm_rd_s, 32'h0);

        // reserved memtype
        run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        chk("rsv_nstr", 32'(n_str), 32'd0);
        chk("rsv_resp", 32'(r_off), 32'd1);
        chk("rsv_err", 32'(r_err), 32'd1);
        chk("rsv_rdhold", r_rd, 32'hFFFFABCD);

        // half ending exactly at the word boundary is not split
        run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        chk("lhb_nstr", 32'(n_str), 32'd1);
        chk("lhb_be", 32'(s_be[0]), 32'hC);
        chk("lhb_resp", 32'(r_off), 32'd3);
        chk("lhb_rd", r_rd, 32'h0000CD33);

        // address wrap on the second access
        preload(32'hFFFFFFFC, 32'h22221111);
        preload(32'h00000000, 32'h44443333);
        run_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
        chk("wrap_a0", s_a[0], 32'hFFFFFFFC);
        chk("wrap_a1", s_a[1], 32'h00000000);
        chk("wrap_be1", 32'(s_be[1]), 32'h3);
        chk("wrap_rd", r_rd, 32'h33332222);

        // reset in ACC1 clears everything immediately
        @(negedge clk);
        req_valid = 1'b1; write_en = 1'b0; memtype = 2'b10; memsign = 1'b0; a = 32'h102;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("acc1_en", 32'(mem_en), 32'd1);
        chk("acc1_a", mem_a, 32'h104);
        rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(mem_en), 32'd0);
        chk("arst_be", 32'(mem_be), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_rd", rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        chk("post_resp", 32'(r_off), 32'd3);
        chk("post_rd", r_rd, 32'h887766AB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
